note_sequencer: RTL and testbench

Programmable song sequencer that drives the tone generator's pitch-select, octave-band and enable inputs from a small on-chip note memory. Each memory entry holds a pitch index, octave band, rest flag, end flag and a duration in beats. The block sits between the switch/button front end and the tone generator. It replaces the manual switches with timed playback and inserts an articulation gap between consecutive notes.

---
 rtl/note_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: timed playback of a small note list into the tone generator.
// Each entry is fetched, decoded, played (or rested) for its beat count, then
// followed by an articulation gap before the next entry is fetched.
module note_sequencer #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_loop,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [15:0]   i_wr_data,
  output logic [15:0]   o_pitch_sel,
  output logic [3:0]    o_band,
  output logic          o_tone_en,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_note_addr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam logic [31:0]   C_BEAT     = 32'(BEAT_CYCLES);
  // Counters run down to zero, so each phase loads its length minus one.
  localparam logic [31:0]   C_GAP_LOAD = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] C_LAST     = AW'(DEPTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_cnt;
  logic [15:0]   r_entry;
  logic          r_done;
  logic [15:0]   r_mem [DEPTH];

  logic          w_restart;   // next fetch is from address 0
  logic          w_advance;   // next fetch is from address + 1
  logic          w_finish;    // natural completion, raise done
  logic          w_step;      // current entry has fully elapsed

  // Entry fields of the captured note
  logic          w_end;
  logic          w_rest;
  logic [3:0]    w_pitch;
  logic [2:0]    w_band;
  logic [6:0]    w_beats;
  logic [31:0]   w_play_load;

  assign w_end   = r_entry[15];
  assign w_rest  = r_entry[14];
  assign w_pitch = r_entry[13:10];
  assign w_band  = r_entry[9:7];
  // A zero beat count still plays for one beat
  assign w_beats = (r_entry[6:0] == 7'd0) ? 7'd1 : r_entry[6:0];
  assign w_play_load = ({25'd0, w_beats} * C_BEAT) - 32'd1;

  // Note memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; stop overrides everything, including a same-cycle start
  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    w_step       = 1'b0;
    if (i_stop) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_state_next = S_FETCH;
            w_restart    = 1'b1;
          end
        end
        S_FETCH: w_state_next = S_DECODE;
        S_DECODE: begin
          if (w_end) begin
            if (i_loop) begin
              w_state_next = S_FETCH;
              w_restart    = 1'b1;
            end else begin
              w_state_next = S_IDLE;
              w_finish     = 1'b1;
            end
          end else begin
            w_state_next = S_PLAY;
          end
        end
        S_PLAY: begin
          if (r_cnt == 32'd0) begin
            if (GAP_CYCLES != 0) begin
              w_state_next = S_GAP;
            end else begin
              w_step = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (r_cnt == 32'd0) begin
            w_step = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
      if (w_step) begin
        if (r_addr != C_LAST) begin
          w_state_next = S_FETCH;
          w_advance    = 1'b1;
        end else if (i_loop) begin
          w_state_next = S_FETCH;
          w_restart    = 1'b1;
        end else begin
          w_state_next = S_IDLE;
          w_finish     = 1'b1;
        end
      end
    end
  end

  // Address, entry capture, duration counter and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_cnt   <= 32'd0;
      r_entry <= 16'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if ((w_state_next == S_IDLE) || w_restart) begin
        r_addr <= '0;
      end else if (w_advance) begin
        r_addr <= r_addr + AW'(1);
      end
      // Reads the pre-write contents when a write hits the same address
      if (r_state == S_FETCH) begin
        r_entry <= r_mem[r_addr];
      end
      if (w_state_next == S_IDLE) begin
        r_cnt <= 32'd0;
      end else if (r_state == S_DECODE) begin
        r_cnt <= w_play_load;
      end else if ((r_state == S_PLAY) && (r_cnt == 32'd0)) begin
        r_cnt <= C_GAP_LOAD;
      end else if (r_cnt != 32'd0) begin
        r_cnt <= r_cnt - 32'd1;
      end
    end
  end

  // Tone generator drive: sound only in PLAY for non-rest entries, band held through GAP
  always_comb begin
    o_pitch_sel = 16'd0;
    o_band      = 4'd0;
    o_tone_en   = 1'b0;
    if ((r_state == S_PLAY) && !w_rest) begin
      o_pitch_sel = 16'd1 << w_pitch;
      o_tone_en   = 1'b1;
    end
    if ((r_state == S_PLAY) || (r_state == S_GAP)) begin
      o_band = {1'b0, w_band};
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_note_addr = r_addr;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: builds the expected per-cycle output timeline of a
// playback straight from the note list and compares the DUT against it.
module tb_note_sequencer;

  localparam int DEPTH = 8;
  localparam int BEAT  = 4;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_in = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;
  logic [15:0] pitch_sel;
  logic [3:0]  band;
  logic        tone_en;
  logic        busy;
  logic        done;
  logic [2:0]  note_addr;

  note_sequencer #(
    .DEPTH(DEPTH),
    .BEAT_CYCLES(BEAT),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(start),
    .i_stop(stop),
    .i_loop(loop_in),
    .i_wr_en(wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_data(wr_data),
    .o_pitch_sel(pitch_sel),
    .o_band(band),
    .o_tone_en(tone_en),
    .o_busy(busy),
    .o_done(done),
    .o_note_addr(note_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model copy of the note memory
  logic [15:0] m [DEPTH];

  // Expected outputs of one cycle: v = {busy, tone_en, done, note_addr[2:0], pitch_sel[15:0]}
  typedef struct {
    logic [21:0] v;
    logic [3:0]  band;
    bit          chk_band;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    m[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic logic [15:0] note(input int p, input int b, input int beats);
    return 16'((p << 10) | (b << 7) | beats);
  endfunction

  // Walk the note list: 2 silent overhead cycles per entry, beats*BEAT cycles of
  // tone (or rest), GAP silent cycles, then the next address or completion.
  task automatic build(input bit lp, input int max_len);
    int a;
    int dur;
    bit fin;
    logic [15:0] d;
    logic [15:0] ps;
    exp_t e;
    a = 0;
    fin = 1'b0;
    q.delete();
    while (!fin && (q.size() < max_len)) begin
      d = m[a];
      e.v = {1'b1, 1'b0, 1'b0, 3'(a), 16'h0};
      e.band = 4'd0;
      e.chk_band = 1'b0;
      q.push_back(e);
      q.push_back(e);
      if (d[15]) begin
        if (lp) begin
          a = 0;
        end else begin
          e.v = 22'd0;
          e.v[19] = 1'b1;
          q.push_back(e);
          fin = 1'b1;
        end
        continue;
      end
      dur = (d[6:0] == 7'd0) ? BEAT : int'(d[6:0]) * BEAT;
      ps = d[14] ? 16'h0 : (16'h1 << d[13:10]);
      e.v = {1'b1, ~d[14], 1'b0, 3'(a), ps};
      e.band = {1'b0, d[9:7]};
      e.chk_band = 1'b1;
      repeat (dur) q.push_back(e);
      e.v = {1'b1, 1'b0, 1'b0, 3'(a), 16'h0};
      repeat (GAP) q.push_back(e);
      if (a < DEPTH - 1) begin
        a++;
      end else if (lp) begin
        a = 0;
      end else begin
        e.v = 22'd0;
        e.v[19] = 1'b1;
        e.chk_band = 1'b0;
        q.push_back(e);
        fin = 1'b1;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {9'd0, busy, tone_en, done, note_addr, pitch_sel, band}, 32'd0);
  endtask

  // Start a playback and compare cycle by cycle for up to max_len cycles.
  // If it has not finished by then, end it with stop (mode 0) or reset (mode 1).
  task automatic play(input string name, input bit lp, input int max_len, input int mode);
    int last;
    build(lp, max_len);
    loop_in = lp;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last = 0;
    for (int i = 0; i < q.size() && i < max_len; i++) begin
      if (i > 0) @(negedge clk);
      check({name, "/out"}, {10'd0, busy, tone_en, done, note_addr, pitch_sel}, {10'd0, q[i].v});
      if (q[i].chk_band) check({name, "/band"}, 32'(band), 32'(q[i].band));
      // A start while busy must be ignored; never pulse it on an idle cycle
      start = q[i].v[21] ? 1'($urandom_range(0, 1)) : 1'b0;
      last = i;
    end
    if (q[last].v[19]) begin
      @(negedge clk);
      check_idle({name, "/after_done"});
    end else if (mode == 1) begin
      start = 1'b0;
      rst = 1'b1;
      #1;
      check_idle({name, "/async_rst"});
      @(negedge clk);
      rst = 1'b0;
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      start = 1'b0;
      check_idle({name, "/after_stop"});
    end
    $display("run %s loop=%0d cycles=%0d ended=%s", name, lp, last + 1,
             q[last].v[19] ? "done" : (mode == 1 ? "reset" : "stop"));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(i, 16'h8000);

    // Single note then END
    wr(0, note(3, 2, 2));
    wr(1, 16'h8000);
    play("one_note", 1'b0, 1000, 0);
    play("stop_in_play", 1'b0, 5, 0);

    // Two one-beat notes at the pitch extremes
    wr(0, note(0, 1, 1));
    wr(1, note(15, 1, 1));
    wr(2, 16'h8000);
    play("two_notes", 1'b0, 1000, 0);
    play("loop_end", 1'b1, 60, 0);

    // Rest between notes, then a zero-beat note
    wr(0, note(5, 3, 1));
    wr(1, 16'h4000 | note(9, 6, 3));
    wr(2, note(7, 4, 0));
    wr(3, 16'h8000);
    play("rest_zero", 1'b0, 1000, 0);

    // No END anywhere: wrap with loop, complete after address 7 without
    for (int i = 0; i < DEPTH; i++) wr(i, note(i * 2, i % 8, 1));
    play("wrap_loop", 1'b1, 100, 0);
    play("last_addr", 1'b0, 1000, 0);

    // start and stop together while idle
    @(negedge clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check_idle("start_stop_idle");
    @(negedge clk);
    check_idle("start_stop_idle2");

    // Reset during the gap, then replay from address 0
    wr(0, note(3, 2, 2));
    wr(1, 16'h8000);
    play("rst_in_gap", 1'b0, 11, 1);
    play("replay", 1'b0, 1000, 0);

    // Random note lists
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wr(i, {($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 3) == 0),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 2))});
      end
      play($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 200, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck run still ends
  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
